// File: rtl/j17_pkg.sv
// j17_pkg: shared constants and types for the J17 fetch/decode/sequencing unit.
// Contents: instruction field widths and bit positions, opcode map,
// controller state enum, PC control codes and RAM access codes.
package j17_pkg;

   localparam int unsigned INSTR_W = 32;
   localparam int unsigned OPC_W   = 5;
   localparam int unsigned ALU_W   = 5;
   localparam int unsigned PC_W    = 4;
   localparam int unsigned OP1_W   = 3;
   localparam int unsigned OP2_W   = 21;
   localparam int unsigned RAM_W   = 2;
   localparam int unsigned CNT_W   = 32;

   // Instruction word layout
   localparam int unsigned OPC_MSB   = 31;
   localparam int unsigned OPC_LSB   = 27;
   localparam int unsigned IMM_BIT   = 26;
   localparam int unsigned FLAG1_BIT = 25;
   localparam int unsigned FLAG_BIT  = 24;
   localparam int unsigned OP1_MSB   = 23;
   localparam int unsigned OP1_LSB   = 21;
   localparam int unsigned OP2_MSB   = 20;

   // Opcode map
   localparam logic [OPC_W-1:0] OPC_NOP       = 5'd0;
   localparam logic [OPC_W-1:0] OPC_MOV       = 5'd1;
   localparam logic [OPC_W-1:0] OPC_ALU_FIRST = 5'd2;
   localparam logic [OPC_W-1:0] OPC_ALU_LAST  = 5'd12;
   localparam logic [OPC_W-1:0] OPC_BR_FIRST  = 5'd16;
   localparam logic [OPC_W-1:0] OPC_BR_LAST   = 5'd24;
   localparam logic [OPC_W-1:0] OPC_BR_BASE   = 5'd15;
   localparam logic [OPC_W-1:0] OPC_HALT      = 5'd31;

   // PC control codes
   localparam logic [PC_W-1:0] PC_STEP = 4'd0;
   localparam logic [PC_W-1:0] PC_HOLD = 4'd10;

   // RAM access codes
   localparam logic [RAM_W-1:0] RAM_NONE  = 2'b00;
   localparam logic [RAM_W-1:0] RAM_READ  = 2'b01;
   localparam logic [RAM_W-1:0] RAM_WRITE = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_MEM    = 3'd3,
      S_EXEC   = 3'd4,
      S_HALT   = 3'd5,
      S_TRAP   = 3'd6
   } state_e;

   // Extract the opcode field of an instruction word
   function automatic logic [OPC_W-1:0] opc_of(input logic [INSTR_W-1:0] w);
      return w[OPC_MSB:OPC_LSB];
   endfunction

endpackage

// File: rtl/j17_control_if.sv
// j17_control_if: instruction-fetch handshake between the J17 controller
// and instruction memory.
//   instr        32  instruction word (memory -> controller)
//   instr_valid   1  instr valid this cycle (memory -> controller)
//   fetch_req     1  fetch request at datapath PC (controller -> memory)
// Modports: master = controller side, slave = instruction memory side.
interface j17_control_if;
   import j17_pkg::*;

   logic [INSTR_W-1:0] instr;
   logic               instr_valid;
   logic               fetch_req;

   modport master (input instr, input instr_valid, output fetch_req);
   modport slave  (output instr, output instr_valid, input fetch_req);

endinterface

// File: rtl/j17_decode.sv
// j17_decode: purely combinational opcode decoder for J17.
//   opcode_i     5  instruction opcode
//   alucode_o    5  ALU operation (opcode-1 for ALU ops, 0 otherwise)
//   writecode_o  1  1 = write num2 (MOV), 0 = write ALU result
//   pc_code_o    4  PC control used in EXEC
//   is_write_o   1  MOV or ALU (produces a register/RAM write)
//   is_branch_o  1  compare/jump opcode
//   is_halt_o    1  HALT opcode
//   illegal_o    1  opcode not in the map
module j17_decode
   import j17_pkg::*;
(
   input  logic [OPC_W-1:0] opcode_i,
   output logic [ALU_W-1:0] alucode_o,
   output logic             writecode_o,
   output logic [PC_W-1:0]  pc_code_o,
   output logic             is_write_o,
   output logic             is_branch_o,
   output logic             is_halt_o,
   output logic             illegal_o
);

   // Opcode classification; NOP falls through every branch with defaults
   always_comb begin
      alucode_o   = '0;
      writecode_o = 1'b0;
      pc_code_o   = PC_STEP;
      is_write_o  = 1'b0;
      is_branch_o = 1'b0;
      is_halt_o   = 1'b0;
      illegal_o   = 1'b0;
      if (opcode_i == OPC_MOV) begin
         writecode_o = 1'b1;
         is_write_o  = 1'b1;
      end else if (opcode_i >= OPC_ALU_FIRST && opcode_i <= OPC_ALU_LAST) begin
         alucode_o  = ALU_W'(opcode_i - 5'd1);
         is_write_o = 1'b1;
      end else if (opcode_i >= OPC_BR_FIRST && opcode_i <= OPC_BR_LAST) begin
         pc_code_o   = PC_W'(opcode_i - OPC_BR_BASE);
         is_branch_o = 1'b1;
      end else if (opcode_i == OPC_HALT) begin
         pc_code_o = PC_HOLD;
         is_halt_o = 1'b1;
      end else if (opcode_i != OPC_NOP) begin
         illegal_o = 1'b1;
      end
   end

endmodule

// File: rtl/j17_control.sv
// j17_control: multi-cycle fetch/decode/sequencing unit for J17.
// Fetches an instruction over the imem handshake, decodes it into the
// datapath control word, holds the PC while an instruction is in flight
// and counts retired instructions.
// Ports:
//   clock, reset   clock and asynchronous active-high reset
//   imem           fetch handshake (master modport)
//   alucode(5) pcControl(4) flag flag1 op1(3) op2(21) imControl writecode
//   regenable ramenable(2) stackSelect(2) halted trap instret(32)
// Optional feature macro: J17_CTRL_TRAP_EN (illegal opcode -> terminal TRAP).
// Without it illegal opcodes execute as NOP and trap is tied low.
module j17_control
   import j17_pkg::*;
(
   input  logic               clock,
   input  logic               reset,
   j17_control_if.master      imem,
   output logic [ALU_W-1:0]   alucode,
   output logic [PC_W-1:0]    pcControl,
   output logic               flag,
   output logic               flag1,
   output logic [OP1_W-1:0]   op1,
   output logic [OP2_W-1:0]   op2,
   output logic               imControl,
   output logic               writecode,
   output logic               regenable,
   output logic [RAM_W-1:0]   ramenable,
   output logic [1:0]         stackSelect,
   output logic               halted,
   output logic               trap,
   output logic [CNT_W-1:0]   instret
);

   state_e             state_q, state_d;
   logic [INSTR_W-1:0] instr_q;
   logic               fetch_req_q;
   logic [ALU_W-1:0]   alucode_q;
   logic [PC_W-1:0]    pc_q;
   logic               flag_q, flag1_q, imm_q, writecode_q, regen_q, halted_q;
   logic [OP1_W-1:0]   op1_q;
   logic [OP2_W-1:0]   op2_q;
   logic [RAM_W-1:0]   ramen_q;
   logic [CNT_W-1:0]   instret_q;

   logic [ALU_W-1:0]   dec_alucode;
   logic               dec_writecode, dec_write, dec_branch, dec_halt, dec_illegal;
   logic [PC_W-1:0]    dec_pc;
   logic               is_mem_access;

   // Decode always looks at the latched word, stable from DECODE to EXEC
   j17_decode u_decode (
      .opcode_i    (opc_of(instr_q)),
      .alucode_o   (dec_alucode),
      .writecode_o (dec_writecode),
      .pc_code_o   (dec_pc),
      .is_write_o  (dec_write),
      .is_branch_o (dec_branch),
      .is_halt_o   (dec_halt),
      .illegal_o   (dec_illegal)
   );

   assign is_mem_access = instr_q[FLAG_BIT] | instr_q[FLAG1_BIT];

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   state_d = S_FETCH;
         S_FETCH:  if (imem.instr_valid) state_d = S_DECODE;
         S_DECODE: begin
`ifdef J17_CTRL_TRAP_EN
            if (dec_illegal)        state_d = S_TRAP;
            else if (is_mem_access) state_d = S_MEM;
            else                    state_d = S_EXEC;
`else
            if (is_mem_access) state_d = S_MEM;
            else               state_d = S_EXEC;
`endif
         end
         S_MEM:    state_d = S_EXEC;
         S_EXEC:   state_d = dec_halt ? S_HALT : S_FETCH;
         S_HALT:   state_d = S_HALT;
         S_TRAP:   state_d = S_TRAP;
         default:  state_d = S_IDLE;
      endcase
   end

   // State, field registers, strobes and retire counter.
   // Strobes are registered from state_d so they are high exactly in EXEC/MEM.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         instr_q     <= '0;
         fetch_req_q <= 1'b0;
         alucode_q   <= '0;
         pc_q        <= PC_HOLD;
         flag_q      <= 1'b0;
         flag1_q     <= 1'b0;
         imm_q       <= 1'b0;
         writecode_q <= 1'b0;
         op1_q       <= '0;
         op2_q       <= '0;
         regen_q     <= 1'b0;
         ramen_q     <= RAM_NONE;
         halted_q    <= 1'b0;
         instret_q   <= '0;
      end else begin
         state_q     <= state_d;
         fetch_req_q <= (state_d == S_FETCH);

         if (state_q == S_FETCH && imem.instr_valid) instr_q <= imem.instr;

         if (state_q == S_DECODE) begin
            alucode_q   <= dec_alucode;
            writecode_q <= dec_writecode;
            imm_q       <= instr_q[IMM_BIT];
            flag1_q     <= instr_q[FLAG1_BIT];
            flag_q      <= instr_q[FLAG_BIT];
            op1_q       <= instr_q[OP1_MSB:OP1_LSB];
            op2_q       <= instr_q[OP2_MSB:0];
         end

         regen_q <= (state_d == S_EXEC) && dec_write && !instr_q[FLAG_BIT];

         if (state_d == S_MEM)
            ramen_q <= RAM_READ;
         else if (state_d == S_EXEC && dec_write && instr_q[FLAG_BIT])
            ramen_q <= RAM_WRITE;
         else
            ramen_q <= RAM_NONE;

         // Illegal opcodes reaching EXEC behave as NOP (dec_pc is PC_STEP)
         if (state_d == S_EXEC)
            pc_q <= dec_branch ? dec_pc : (dec_halt ? PC_HOLD : PC_STEP);
         else
            pc_q <= PC_HOLD;

         if (state_q == S_EXEC) begin
            if (dec_halt) halted_q  <= 1'b1;
            else          instret_q <= instret_q + CNT_W'(1);
         end
      end
   end

`ifdef J17_CTRL_TRAP_EN
   logic trap_q;

   // Sticky trap flag, set on the edge leaving DECODE
   always_ff @(posedge clock or posedge reset) begin
      if (reset)                                trap_q <= 1'b0;
      else if (state_q == S_DECODE && dec_illegal) trap_q <= 1'b1;
   end

   assign trap = trap_q;
`else
   logic unused_illegal;
   assign unused_illegal = dec_illegal;
   assign trap           = 1'b0;
`endif

   assign imem.fetch_req = fetch_req_q;
   assign alucode        = alucode_q;
   assign pcControl      = pc_q;
   assign flag           = flag_q;
   assign flag1          = flag1_q;
   assign op1            = op1_q;
   assign op2            = op2_q;
   assign imControl      = imm_q;
   assign writecode      = writecode_q;
   assign regenable      = regen_q;
   assign ramenable      = ramen_q;
   assign stackSelect    = 2'b00;
   assign halted         = halted_q;
   assign instret        = instret_q;

endmodule

// File: tb/tb_j17_control.sv
// tb_j17_control: scoreboard bench for j17_control. Stimulus pushes the
// expected EXEC control word; a monitor pops and compares on every EXEC.
module tb_j17_control;
   import j17_pkg::*;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [4:0]  alucode;
   logic [3:0]  pcControl;
   logic        flag, flag1, imControl, writecode, regenable, halted, trap;
   logic [2:0]  op1;
   logic [20:0] op2;
   logic [1:0]  ramenable, stackSelect;
   logic [31:0] instret;

   always #5 clock = ~clock;

   j17_control_if imem();

   j17_control dut (
      .clock       (clock),
      .reset       (reset),
      .imem        (imem),
      .alucode     (alucode),
      .pcControl   (pcControl),
      .flag        (flag),
      .flag1       (flag1),
      .op1         (op1),
      .op2         (op2),
      .imControl   (imControl),
      .writecode   (writecode),
      .regenable   (regenable),
      .ramenable   (ramenable),
      .stackSelect (stackSelect),
      .halted      (halted),
      .trap        (trap),
      .instret     (instret)
   );

   typedef struct {
      logic [4:0]  alu;
      logic        wc;
      logic [3:0]  pc;
      logic        regen;
      logic [1:0]  ramen;
      logic [2:0]  op1;
      logic [20:0] op2;
      logic        im, fl, fl1, mem;
      int          exp_cyc;
   } exp_t;

   exp_t sb_q[$];
   int   vec_cnt = 0;
   int   err_cnt = 0;
   int   cyc     = 0;
   int   exp_instret;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Expected record: control-word values given by the caller, fields taken from the word layout
   function automatic exp_t mk(input logic [31:0] w, input logic [4:0] alu, input logic wc,
                               input logic [3:0] pc, input logic regen, input logic [1:0] ramen);
      exp_t e;
      e.alu = alu; e.wc = wc; e.pc = pc; e.regen = regen; e.ramen = ramen;
      e.op1 = w[23:21]; e.op2 = w[20:0];
      e.im = w[26]; e.fl1 = w[25]; e.fl = w[24];
      e.mem = w[25] | w[24];
      e.exp_cyc = 0;
      return e;
   endfunction

   // Bounded wait (at negedge) for fetch_req
   task automatic wait_fetch();
      int n = 0;
      while (imem.fetch_req !== 1'b1 && n < 40) begin
         @(negedge clock);
         n++;
      end
      if (imem.fetch_req !== 1'b1) chk("fetch_req_timeout", 32'(imem.fetch_req), 32'd1);
   endtask

   // Serve one fetch after 'delay' wait cycles; garbage valid follows to show it is ignored
   task automatic issue(input logic [31:0] word, input int delay, input exp_t e_in, input bit push);
      exp_t e;
      e = e_in;
      wait_fetch();
      for (int i = 0; i < delay; i++) begin
         chk("wait_fetch_req", 32'(imem.fetch_req), 32'd1);
         chk("wait_pc_hold", 32'(pcControl), 32'(PC_HOLD));
         @(negedge clock);
      end
      chk("fetch_req_at_valid", 32'(imem.fetch_req), 32'd1);
      imem.instr       = word;
      imem.instr_valid = 1'b1;
      e.exp_cyc = cyc + 2 + (e.mem ? 1 : 0);
      if (push) sb_q.push_back(e);
      @(negedge clock);
      imem.instr = 32'hFFFF_FFFF;
      @(negedge clock);
      imem.instr_valid = 1'b0;
   endtask

   // Monitor: EXEC is visible as pcControl != hold; MEM as ramenable == read
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (!reset) begin
            if (pcControl != PC_HOLD) begin
               if (sb_q.size() == 0) chk("unexpected_exec", 32'd1, 32'd0);
               else begin
                  e = sb_q.pop_front();
                  chk("exec_cycle", 32'(cyc), 32'(e.exp_cyc));
                  chk("alucode", 32'(alucode), 32'(e.alu));
                  chk("writecode", 32'(writecode), 32'(e.wc));
                  chk("pcControl", 32'(pcControl), 32'(e.pc));
                  chk("regenable", 32'(regenable), 32'(e.regen));
                  chk("ramenable", 32'(ramenable), 32'(e.ramen));
                  chk("op1", 32'(op1), 32'(e.op1));
                  chk("op2", 32'(op2), 32'(e.op2));
                  chk("imControl", 32'(imControl), 32'(e.im));
                  chk("flag", 32'(flag), 32'(e.fl));
                  chk("flag1", 32'(flag1), 32'(e.fl1));
                  chk("stackSelect", 32'(stackSelect), 32'd0);
               end
            end else begin
               chk("no_strobe_outside_exec", {30'd0, regenable, ramenable == RAM_WRITE}, 32'd0);
            end
            if (ramenable == RAM_READ) begin
               if (sb_q.size() == 0) chk("unexpected_mem", 32'd1, 32'd0);
               else begin
                  chk("mem_needed", 32'(sb_q[0].mem), 32'd1);
                  chk("mem_cycle", 32'(cyc), 32'(sb_q[0].exp_cyc - 1));
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] w;
      imem.instr       = '0;
      imem.instr_valid = 1'b0;
      reset            = 1'b1;
      exp_instret      = 0;
      repeat (3) @(negedge clock);

      // Reset values
      chk("rst_fetch_req", 32'(imem.fetch_req), 32'd0);
      chk("rst_pcControl", 32'(pcControl), 32'd10);
      chk("rst_alucode", 32'(alucode), 32'd0);
      chk("rst_regenable", 32'(regenable), 32'd0);
      chk("rst_ramenable", 32'(ramenable), 32'd0);
      chk("rst_op2", 32'(op2), 32'd0);
      chk("rst_instret", instret, 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_trap", 32'(trap), 32'd0);

      reset = 1'b0;
      #1 chk("idle_fetch_req", 32'(imem.fetch_req), 32'd0);
      @(negedge clock);
      chk("fetch_req_rise", 32'(imem.fetch_req), 32'd1);

      // ADD r3, #5
      w = {5'd2, 1'b1, 2'b00, 3'd3, 21'd5};
      issue(w, 0, mk(w, 5'd1, 1'b0, 4'd0, 1'b1, 2'b00), 1'b1);
      wait_fetch(); exp_instret = 1;
      chk("instret_add", instret, 32'(exp_instret));

      // MOV with flag=1: MEM read then RAM write
      w = {5'd1, 1'b0, 1'b0, 1'b1, 3'd2, 21'h01234};
      issue(w, 0, mk(w, 5'd0, 1'b1, 4'd0, 1'b0, 2'b10), 1'b1);
      wait_fetch(); exp_instret = 2;
      chk("instret_mov", instret, 32'(exp_instret));

      // Branch opcode 20 -> pcControl 5
      w = {5'd20, 3'b000, 3'd1, 21'd100};
      issue(w, 0, mk(w, 5'd0, 1'b0, 4'd5, 1'b0, 2'b00), 1'b1);
      wait_fetch(); exp_instret = 3;
      chk("instret_branch", instret, 32'(exp_instret));

      // SHL with flag1=1: MEM read, register write
      w = {5'd12, 1'b0, 1'b1, 1'b0, 3'd7, 21'h1FFFFF};
      issue(w, 0, mk(w, 5'd11, 1'b0, 4'd0, 1'b1, 2'b00), 1'b1);
      wait_fetch(); exp_instret = 4;
      chk("instret_shl", instret, 32'(exp_instret));

      // Illegal opcode 14
      w = {5'd14, 1'b1, 2'b00, 3'd4, 21'd9};
`ifdef J17_CTRL_TRAP_EN
      issue(w, 0, mk(w, 5'd0, 1'b0, 4'd0, 1'b0, 2'b00), 1'b0);
      repeat (6) @(negedge clock);
      chk("trap_set", 32'(trap), 32'd1);
      chk("trap_pc_hold", 32'(pcControl), 32'd10);
      chk("trap_no_fetch", 32'(imem.fetch_req), 32'd0);
      chk("trap_instret", instret, 32'(exp_instret));
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      exp_instret = 0;
      @(negedge clock);
`else
      issue(w, 0, mk(w, 5'd0, 1'b0, 4'd0, 1'b0, 2'b00), 1'b1);
      wait_fetch(); exp_instret = 5;
      chk("instret_illegal_nop", instret, 32'(exp_instret));
      chk("trap_tied_low", 32'(trap), 32'd0);
`endif

      // Counter wrap
      wait_fetch();
      force dut.instret_q = 32'hFFFF_FFFF;
      @(negedge clock);
      release dut.instret_q;
      w = {5'd0, 3'b000, 3'd5, 21'd77};
      issue(w, 0, mk(w, 5'd0, 1'b0, 4'd0, 1'b0, 2'b00), 1'b1);
      wait_fetch(); exp_instret = 0;
      chk("instret_wrap", instret, 32'(exp_instret));

      // HALT after 3 wait cycles
      w = {5'd31, 27'd0};
      issue(w, 3, mk(w, 5'd0, 1'b0, 4'd10, 1'b0, 2'b00), 1'b0);
      repeat (6) @(negedge clock);
      chk("halted", 32'(halted), 32'd1);
      chk("halt_pc_hold", 32'(pcControl), 32'd10);
      chk("halt_no_fetch", 32'(imem.fetch_req), 32'd0);
      chk("halt_instret", instret, 32'(exp_instret));

      // Reset while in MEM
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      w = {5'd1, 1'b0, 1'b0, 1'b1, 3'd6, 21'd3};
      issue(w, 0, mk(w, 5'd0, 1'b1, 4'd0, 1'b0, 2'b10), 1'b1);
      chk("in_mem", 32'(ramenable), 32'(RAM_READ));
      #1 reset = 1'b1;
      #1;
      chk("memrst_fetch_req", 32'(imem.fetch_req), 32'd0);
      chk("memrst_pcControl", 32'(pcControl), 32'd10);
      chk("memrst_ramenable", 32'(ramenable), 32'd0);
      chk("memrst_regenable", 32'(regenable), 32'd0);
      chk("memrst_halted", 32'(halted), 32'd0);
      chk("memrst_op1", 32'(op1), 32'd0);
      chk("memrst_instret", instret, 32'd0);
      sb_q.delete();
      reset = 1'b0;
      #1 chk("memrst_idle", 32'(imem.fetch_req), 32'd0);
      @(negedge clock);
      chk("memrst_fetch", 32'(imem.fetch_req), 32'd1);
      repeat (3) @(negedge clock);
      chk("memrst_no_retire", instret, 32'd0);
      chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/j17_control.md
# j17_control

Multi-cycle fetch/decode/sequencing unit for the J17 processor. It requests 32-bit instructions from instruction memory at the current PC and decodes each one into the control word consumed by the J17 datapath: ALU code, operands, addressing flags, write source and PC control. It paces the datapath by driving PC-hold while an instruction is in flight, and counts retired instructions.

## Interface
- No parameters. Widths are fixed by the J17 instruction format.
- clock  in  1  processor clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; forces state IDLE and clears every register.
- instr  in  32  instruction word from instruction memory.
- instr_valid  in  1  `instr` is valid this cycle; sampled only in FETCH.
- fetch_req  out  1  high in FETCH; requests the instruction at the datapath PC.
- alucode  out  5  ALU operation.
- pcControl  out  4  PC update code: 0 = step, 1–9 = compare/jump, 10 = hold.
- flag  out  1  op1 is memory-indirect.
- flag1  out  1  op2 is memory-indirect.
- op1  out  3  destination/first register.
- op2  out  21  immediate value or register field.
- imControl  out  1  op2 is an immediate.
- writecode  out  1  0 = write ALU result; 1 = write num2.
- regenable  out  1  register-write qualifier.
- ramenable  out  2  RAM access: 01 = read, 10 = write.
- stackSelect  out  2  reserved; constant 2'b00.
- halted  out  1  HALT instruction executed.
- trap  out  1  illegal opcode fetched (feature-dependent).
- instret  out  32  retired-instruction counter.

## Operation
- Instruction format:
  - [31:27] opcode
  - [26] imControl
  - [25] flag1
  - [24] flag
  - [23:21] op1
  - [20:0] op2
- Opcode map:
  - 0 NOP
  - 1 MOV: alucode 0, writecode 1
  - 2–12 ALU: alucode = opcode−1 (ADD through SHL), writecode 0
  - 16–24 branch: pcControl = opcode−15, no register write
  - 31 HALT
  - all other opcodes illegal
- States:
  - IDLE → FETCH.
  - FETCH: wait for instr_valid, then latch `instr` → DECODE.
  - DECODE → MEM if (flag | flag1), else → EXEC.
  - MEM: one cycle, ramenable = 01 → EXEC.
  - EXEC: one cycle → FETCH, or → HALT for opcode 31.
  - HALT: terminal until reset.
  - TRAP: terminal until reset.
- Field outputs (op1, op2, imControl, flag, flag1, alucode, writecode) are registered in DECODE and held until the next DECODE.
- Strobes asserted only in EXEC:
  - regenable = 1 for MOV/ALU with flag = 0.
  - ramenable = 10 for MOV/ALU with flag = 1.
- pcControl:
  - 10 in every state except EXEC.
  - In EXEC: 0 for NOP/MOV/ALU, decoded value for branches, 10 for HALT.
- instret increments by 1 on each EXEC cycle except HALT; wraps 0xFFFFFFFF → 0.
- Reset mid-instruction abandons it: no strobe is issued and no retire is counted.

## Timing
- Reset values:
  - state IDLE
  - all outputs 0 except pcControl = 4'd10
  - instret = 0
- fetch_req rises the first cycle after reset deasserts (IDLE lasts one cycle).
- Minimum latency from fetch_req to EXEC:
  - 3 cycles for a register-only instruction with instr_valid in the first FETCH cycle.
  - 4 cycles with a MEM cycle.
- Each FETCH wait cycle adds 1 to latency.
- instr_valid outside FETCH is ignored.
- The datapath PC advances only on the EXEC edge.
- halted and trap are set on the edge leaving EXEC/DECODE respectively and stay high until reset.

## Configuration
- Macro: J17_CTRL_TRAP_EN.
- Defined: an illegal opcode causes DECODE → TRAP; trap = 1; pcControl held at 10; no strobes.
- Undefined: an illegal opcode executes as a NOP (pc step, counted in instret); trap is tied to 0.

## Structure
- Package j17_pkg holds:
  - opcode constants
  - state enum
  - PC_STEP = 0 and PC_HOLD = 10
  - ramenable codes
  - field bit positions
- Sub-module j17_decode: purely combinational opcode → {alucode, writecode, pcControl, is_write, is_branch, is_halt, illegal}.
- The FSM, field registers and instret live in j17_control.

## Test plan
- ADD with instr = {5'd2, 1'b1, 2'b00, 3'd3, 21'd5} and instr_valid in the first cycle:
  - alucode = 1, imControl = 1, op1 = 3, op2 = 5
  - regenable = 1 only in the 3rd cycle; pcControl = 0 there, 10 elsewhere
  - instret = 1
- MOV with flag = 1: one MEM cycle with ramenable = 01, then EXEC with ramenable = 10 and regenable = 0; 4-cycle latency.
- Branch opcode 20: pcControl = 5 in EXEC only; regenable = 0; instret increments.
- instr_valid delayed 3 cycles: fetch_req held for 4 cycles, pcControl = 10 throughout the wait; HALT afterwards → halted = 1, pcControl stays 10, fetch_req stays 0.
- Opcode 14:
  - With J17_CTRL_TRAP_EN: trap = 1, no strobes, stuck.
  - Without: behaves as a NOP with instret + 1.
- Preload instret to 0xFFFFFFFF via run, execute one more → 0. Assert reset in MEM → all outputs at reset values immediately, IDLE, then FETCH on the next cycle.
